// File: rtl/weight_loader_if.sv
// Stream and array-side signals of the weight loader, bundled as one port.
// master: memory/sequencer side driving the request and weight stream.
// slave:  the loader itself.
interface weight_loader_if #(
    parameter int DATA_WIDTH = 16,
    parameter int COLS       = 2
);
    logic                         start;
    logic signed [DATA_WIDTH-1:0] w_data_in;
    logic                         w_valid_in;
    logic                         w_ready_out;
    logic [COLS*DATA_WIDTH-1:0]   wl_weight_out;
    logic [COLS-1:0]              wl_accept_w_out;
    logic                         wl_switch_out;
    logic                         busy;
    logic                         done;

    modport master (
        output start, w_data_in, w_valid_in,
        input  w_ready_out, wl_weight_out, wl_accept_w_out,
               wl_switch_out, busy, done
    );

    modport slave (
        input  start, w_data_in, w_valid_in,
        output w_ready_out, wl_weight_out, wl_accept_w_out,
               wl_switch_out, busy, done
    );
endinterface

// File: rtl/weight_loader.sv
// Weight tile loader: buffers one ROWS x COLS tile from a valid/ready stream
// (row-major), then shifts it down the PE columns with a one-cycle skew per
// column, bottom row first, and finishes with a single swap pulse.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start, no outputs active
// FILL   | accepting ROWS*COLS words into the tile buffer
// SHIFT  | ROWS+COLS-1 skewed cycles driving weights into the columns
// SWITCH | one cycle: swap pulse to the array, done pulse
module weight_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int ROWS       = 2,
    parameter int COLS       = 2
) (
    input logic            clk,
    input logic            rst,
    weight_loader_if.slave wl
);
    localparam int NWORDS  = ROWS * COLS;
    localparam int NSHIFT  = ROWS + COLS - 1;
    localparam int CNT_MAX = (NWORDS > NSHIFT) ? NWORDS : NSHIFT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        SHIFT  = 2'd2,
        SWITCH = 2'd3
    } state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic                    accept;
    logic [DATA_WIDTH-1:0]   wbuf     [NWORDS];
    logic [DATA_WIDTH-1:0]   wbuf_nxt [NWORDS];
    logic [COLS*DATA_WIDTH-1:0] weight_q, weight_nxt;
    logic [COLS-1:0]         acc_q, acc_nxt;

    assign accept = (state == FILL) && wl.w_valid_in;

    // State and shared word/shift counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic; cnt is the word index in FILL and shift cycle t in SHIFT.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (wl.start) begin
                    state_nxt = FILL;
                    cnt_nxt   = '0;
                end
            end
            FILL: begin
                if (wl.w_valid_in) begin
                    if (cnt == CNT_W'(NWORDS - 1)) begin
                        state_nxt = SHIFT;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            SHIFT: begin
                if (cnt == CNT_W'(NSHIFT - 1)) begin
                    state_nxt = SWITCH;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            SWITCH: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Buffer view including this cycle's write, so the first shift cycle can
    // already use the final word accepted on the same edge.
    always_comb begin
        for (int k = 0; k < NWORDS; k++) begin
            wbuf_nxt[k] = (accept && cnt == CNT_W'(k)) ? wl.w_data_in : wbuf[k];
        end
    end

    // Tile buffer, written only while filling.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NWORDS; k++) wbuf[k] <= '0;
        end else begin
            for (int k = 0; k < NWORDS; k++) wbuf[k] <= wbuf_nxt[k];
        end
    end

    // Output decode one cycle ahead: column c at shift cycle t takes row
    // ROWS-1-(t-c), so it is active only while that row index is in range.
    always_comb begin
        weight_nxt = '0;
        acc_nxt    = '0;
        if (state_nxt == SHIFT) begin
            for (int c = 0; c < COLS; c++) begin
                for (int r = 0; r < ROWS; r++) begin
                    if (int'(cnt_nxt) == c + (ROWS - 1 - r)) begin
                        acc_nxt[c]                            = 1'b1;
                        weight_nxt[c*DATA_WIDTH +: DATA_WIDTH] = wbuf_nxt[r*COLS + c];
                    end
                end
            end
        end
    end

    // Registered column drive towards the array.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            weight_q <= '0;
            acc_q    <= '0;
        end else begin
            weight_q <= weight_nxt;
            acc_q    <= acc_nxt;
        end
    end

    assign wl.wl_weight_out   = weight_q;
    assign wl.wl_accept_w_out = acc_q;
    assign wl.w_ready_out     = (state == FILL);
    assign wl.busy            = (state != IDLE);
    assign wl.done            = (state == SWITCH);
    assign wl.wl_switch_out   = (state == SWITCH);
endmodule

// File: doc/weight_loader.md
WEIGHT_LOADER -- requirements
Module: weight_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, signed fixed-point weight width.
REQ-002 SHALL have parameter ROWS, default 2, number of PEs chained vertically per column.
REQ-003 SHALL have parameter COLS, default 2, number of PE columns driven.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low (asserted at 0).
REQ-006 SHALL have port start  input  1  one-cycle request to load one weight tile.
REQ-007 SHALL have port w_data_in  input  DATA_WIDTH  signed weight word from memory stream.
REQ-008 SHALL have port w_valid_in  input  1  w_data_in valid.
REQ-009 SHALL have port w_ready_out  output  1  loader accepts w_data_in this cycle.
REQ-010 SHALL have port wl_weight_out  output  COLS*DATA_WIDTH  weight to top PE of each column, column c in bits [c*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have port wl_accept_w_out  output  COLS  per-column weight-accept strobe.
REQ-012 SHALL have port wl_switch_out  output  1  inactive-to-active weight swap pulse for the array.
REQ-013 SHALL have port busy  output  1  high from accepted start until done.
REQ-014 SHALL have port done  output  1  one-cycle pulse at tile completion.

Function
REQ-015 SHALL implement FSM states IDLE, FILL, SHIFT, SWITCH; reset state IDLE.
REQ-016 IDLE: start=1 SHALL move to FILL next cycle, clear word counter, set busy; start outside IDLE SHALL be ignored.
REQ-017 FILL: w_ready_out SHALL be 1; a word SHALL be stored only when w_valid_in and w_ready_out are both 1 on a rising edge.
REQ-018 FILL: words SHALL arrive row-major, word k stored at buf[k/COLS][k%COLS], k = 0..ROWS*COLS-1.
REQ-019 FILL: after word ROWS*COLS-1 is accepted, w_ready_out SHALL fall next cycle and FSM SHALL enter SHIFT; stalls (w_valid_in=0) SHALL hold state indefinitely.
REQ-020 w_ready_out SHALL be 0 in every state but FILL.
REQ-021 SHIFT SHALL last exactly ROWS+COLS-1 cycles, shift cycle t = 0..ROWS+COLS-2.
REQ-022 In SHIFT cycle t, column c SHALL be active iff c <= t <= c+ROWS-1 (one-cycle skew per column).
REQ-023 Active column c SHALL drive wl_accept_w_out[c]=1 and weight buf[ROWS-1-(t-c)][c] (bottom row first, top row last).
REQ-024 Inactive columns, and all columns outside SHIFT, SHALL drive wl_accept_w_out[c]=0 and weight 0.
REQ-025 wl_weight_out and wl_accept_w_out SHALL be registered outputs, changing only on clock edges.
REQ-026 After the last SHIFT cycle FSM SHALL enter SWITCH for exactly one cycle, wl_switch_out=1, done=1.
REQ-027 From SWITCH FSM SHALL return to IDLE; busy SHALL be 0 from that IDLE cycle; start in the SWITCH cycle SHALL be ignored.
REQ-028 Weight values SHALL pass unmodified (no rounding, saturation or sign change).
REQ-029 Stored buffer SHALL be unchanged during SHIFT regardless of w_valid_in.

Reset
REQ-030 rst=0 SHALL asynchronously force IDLE, counters 0, buffer 0, w_ready_out=0, wl_weight_out=0, wl_accept_w_out=0, wl_switch_out=0, busy=0, done=0.
REQ-031 rst asserted mid-FILL or mid-SHIFT SHALL abort the tile with no further accept or switch pulses; after release, a new start SHALL be required.

Verification (ROWS=2, COLS=2, DATA_WIDTH=16)
REQ-032 Start, stream 1,2,3,4 back-to-back -> w_ready_out high exactly 4 accepting cycles; SHIFT col0 weights 3 then 1 at t=0,1; col1 weights 4 then 2 at t=1,2; accept masks 01,11,10; then switch+done pulse one cycle; busy falls next cycle.
REQ-033 Same tile with w_valid_in low for 3 cycles between words 2 and 3 -> identical SHIFT/switch sequence, shifted later by 3 cycles, no extra word stored.
REQ-034 start pulsed during FILL and during SHIFT -> no effect; exactly one done per tile.
REQ-035 rst=0 for one cycle at SHIFT t=1 -> all outputs 0 immediately (asynchronously), no switch pulse; after rst=1, with start held 0, outputs stay 0 and w_ready_out stays 0.
REQ-036 Weights 0x8000 and 0x7FFF loaded -> appear bit-exact on wl_weight_out; outside accept cycles wl_weight_out=0.
